sram_stream_reader: RTL and testbench
=====================================

# sram_stream_reader

Read-side master for the single-port synchronous feature-map SRAM (1-cycle registered read, combined addr/wdata/ena port). It accepts a burst command (base address, word count), drives sequential read addresses into the SRAM, and re-times the returned words into a valid/ready stream through a small credit-controlled FIFO, so downstream back-pressure never loses an SRAM word. It sits between the feature-map SRAM and the conv input buffer loader.

## Interface
- WL_ADDR, 8, SRAM address width
- WL_DATA, 32, SRAM/stream data width
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2
- Reset is rst, asynchronous, active-low; clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high in IDLE only
- cmd_base  in  WL_ADDR  first word address
- cmd_len  in  WL_ADDR+1  word count; 0 = empty burst
- mem_addr  out  WL_ADDR  SRAM address
- mem_wdata  out  WL_DATA  constant 0
- mem_ena  out  1  SRAM write enable, constant 0
- mem_rdata  in  WL_DATA  SRAM read data, valid the cycle after its address
- m_valid  out  1  stream word valid (FIFO not empty)
- m_ready  in  1  downstream accept
- m_data  out  WL_DATA  FIFO head word
- m_last  out  1  head word is the burst's final word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: latch addr_cnt=cmd_base, rem=cmd_len. If cmd_len≠0 → RUN; if cmd_len=0 → stay IDLE, done pulses next cycle, no SRAM access, no stream word.
- RUN: mem_addr=addr_cnt (combinational from counter). Issue a read in a cycle iff credit: fifo_count + rd_pend − (m_valid&m_ready) < FIFO_DEPTH. On issue: addr_cnt+1 (mod 2^WL_ADDR, wraps 0xFF→0x00 at default width), rem−1, rd_pend<=1, last_pend<=(rem==1). Issuing the final word → DRAIN. No issue → rd_pend<=0, addr held.
- rd_pend=1 in cycle t: mem_rdata pushed into FIFO at end of t with m_last tag = last_pend. Push and pop in same cycle allowed; count unchanged.
- DRAIN: no issues. When fifo_count=0 and rd_pend=0 → IDLE, done=1 for that next cycle.
- cmd_len > 2^WL_ADDR: addresses wrap and re-read; count honored exactly.
- mem_ena and mem_wdata never nonzero.
- Reset mid-burst: FIFO flushed, burst abandoned, no done.

## Timing
- Reset values: cmd_ready=1 (IDLE), mem_addr=0, mem_ena=0, mem_wdata=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; fifo_count, rd_pend, rem, pointers=0.
- Command accepted in C0 → first address on mem_addr in C1 → mem_rdata valid C2 → m_valid=1 in C3 (3 cycles).
- With m_ready held high and FIFO_DEPTH≥2: one word per cycle, no bubbles.
- m_valid/m_data/m_last stable while m_valid&!m_ready.
- done pulses and cmd_ready rises the cycle after last-word handshake; new command accepted that same cycle.
- FIFO never overflows: credit counts in-flight read.

## Test plan
- SRAM preloaded mem[i]=i+0x100; cmd base=0x10 len=4, m_ready=1 → m_data 0x110,0x111,0x112,0x113 in C3..C6, m_last only in C6, done in C7, busy C1..C6.
- Same command, m_ready=0 until C10 → mem_addr stops after 4 issues (FIFO full), then 0x110..0x113 drain C10..C13 in order, no loss/duplication.
- base=0xFE len=4 → words from addresses 0xFE,0xFF,0x00,0x01; m_last on 4th.
- cmd len=0 → no m_valid, done=1 one cycle after acceptance, busy stays 0.
- Random m_ready (50%) over len=256 from base 0 → 256 words in address order, m_last exactly once, fifo_count never > FIFO_DEPTH, mem_ena always 0.
- rst low during C5 of a len=8 burst → all outputs at reset values immediately; subsequent len=2 burst returns only its own 2 words.

Source files
------------

// File: rtl/sram_stream_reader_if.sv
// Command, SRAM-port and output-stream signals of the feature-map SRAM reader.
// master is the reader's view; slave is the surrounding environment.
interface sram_stream_reader_if #(
  parameter int WL_ADDR = 8,
  parameter int WL_DATA = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WL_ADDR-1:0] cmd_base;
  logic [WL_ADDR:0]   cmd_len;
  logic [WL_ADDR-1:0] mem_addr;
  logic [WL_DATA-1:0] mem_wdata;
  logic               mem_ena;
  logic [WL_DATA-1:0] mem_rdata;
  logic               m_valid;
  logic               m_ready;
  logic [WL_DATA-1:0] m_data;
  logic               m_last;
  logic               busy;
  logic               done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, mem_rdata, m_ready,
    output cmd_ready, mem_addr, mem_wdata, mem_ena, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, mem_rdata, m_ready,
    input  cmd_ready, mem_addr, mem_wdata, mem_ena, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Burst read master for the feature-map SRAM: issues sequential addresses and
// re-times the 1-cycle-late read data into a valid/ready stream via a credited FIFO.
module sram_stream_reader #(
  parameter int WL_ADDR    = 8,
  parameter int WL_DATA    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_stream_reader_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]      DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0]      PTR_ONE  = PW'(1);
  localparam logic [WL_ADDR-1:0] ADDR_ONE = WL_ADDR'(1);
  localparam logic [WL_ADDR:0]   LEN_ONE  = (WL_ADDR + 1)'(1);
  localparam logic [WL_ADDR:0]   LEN_ZERO = {(WL_ADDR + 1){1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  logic [WL_ADDR-1:0] addr_cnt_r;
  logic [WL_ADDR:0]   rem_r;
  logic               rd_pend_r;
  logic               last_pend_r;
  logic               cmd_ready_r;
  logic               busy_r;
  logic               done_r;

  logic [WL_DATA-1:0]    fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  valid_r;

  logic          pop_s;
  logic [CW-1:0] count_next_s;
  logic          issue_s;

  // The in-flight read is already counted, so credit is simply the next occupancy.
  assign pop_s        = valid_r & bus.m_ready;
  assign count_next_s = count_r + {{(CW-1){1'b0}}, rd_pend_r} - {{(CW-1){1'b0}}, pop_s};
  assign issue_s      = (state_r == RUN) && (count_next_s < DEPTH_C);

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.mem_addr  = addr_cnt_r;
  assign bus.mem_wdata = {WL_DATA{1'b0}};
  assign bus.mem_ena   = 1'b0;
  assign bus.m_valid   = valid_r;
  assign bus.m_data    = fifo_data_r[rd_ptr_r];
  assign bus.m_last    = fifo_last_r[rd_ptr_r];

  // Burst sequencer: command latch, address issue and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      addr_cnt_r  <= {WL_ADDR{1'b0}};
      rem_r       <= LEN_ZERO;
      rd_pend_r   <= 1'b0;
      last_pend_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      rd_pend_r   <= issue_s;
      last_pend_r <= issue_s ? (rem_r == LEN_ONE) : last_pend_r;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_cnt_r <= bus.cmd_base;
            rem_r      <= bus.cmd_len;
            if (bus.cmd_len != LEN_ZERO) begin
              state_r     <= RUN;
              cmd_ready_r <= 1'b0;
              busy_r      <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            addr_cnt_r <= addr_cnt_r + ADDR_ONE;
            rem_r      <= rem_r - LEN_ONE;
            if (rem_r == LEN_ONE) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (count_next_s == CNT_ZERO) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO: SRAM word pushed in the cycle its read data is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {WL_DATA{1'b0}};
      end
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      valid_r     <= 1'b0;
    end else begin
      if (rd_pend_r) begin
        fifo_data_r[wr_ptr_r] <= bus.mem_rdata;
        fifo_last_r[wr_ptr_r] <= last_pend_r;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != CNT_ZERO);
    end
  end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: directed timing checks plus randomized bursts
// scored against a queue of words predicted from the SRAM image.
module tb_sram_stream_reader;
  localparam int WL_ADDR    = 8;
  localparam int WL_DATA    = 32;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_stream_reader_if #(.WL_ADDR(WL_ADDR), .WL_DATA(WL_DATA)) bus ();

  sram_stream_reader #(.WL_ADDR(WL_ADDR), .WL_DATA(WL_DATA), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int extra_words = 0;
  int ena_bad = 0;
  int ovf_bad = 0;
  bit ready_force = 1'b0;
  bit rand_mode = 1'b0;

  logic [WL_DATA-1:0] sram [256];
  logic [WL_DATA:0]   exp_q [$];
  logic               prev_stall = 1'b0;
  logic [WL_DATA-1:0] prev_data;
  logic               prev_last;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h100 + i;
  end

  // SRAM model: registered read, data valid the cycle after its address
  always @(posedge clk) bus.mem_rdata <= sram[bus.mem_addr];

  always @(posedge clk) begin
    #2;
    bus.m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and invariant monitor
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.mem_ena !== 1'b0 || bus.mem_wdata !== '0) ena_bad <= ena_bad + 1;
      if (dut.count_r > FIFO_DEPTH) ovf_bad <= ovf_bad + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (prev_stall) begin
        check_eq("stall_valid", bus.m_valid, 1'b1);
        check_eq("stall_data", bus.m_data, prev_data);
        check_eq("stall_last", bus.m_last, prev_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (bus.m_last) last_cnt <= last_cnt + 1;
        if (exp_q.size() == 0) begin
          extra_words <= extra_words + 1;
        end else begin
          check_eq("sb_data", bus.m_data, exp_q[0][WL_DATA-1:0]);
          check_eq("sb_last", bus.m_last, exp_q[0][WL_DATA]);
          exp_q.delete(0);
        end
      end
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
      prev_last  <= bus.m_last;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Call at posedge+1; returns at the negedge of the accepting cycle.
  task automatic send_cmd(input logic [WL_ADDR-1:0] base, input logic [WL_ADDR:0] len);
    bit acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("cmd_accept", acc, 1'b1);
    if (acc) begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back({(i == int'(len) - 1), sram[WL_ADDR'(int'(base) + i)]});
    end
  endtask

  task automatic wait_done(input int limit, input string tag);
    bit got = 1'b0;
    for (int n = 0; n < limit; n++) begin
      next_cycle();
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    check_eq(tag, got, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lc;
    int dc;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_eq("rst_mem_addr", bus.mem_addr, 8'h00);
    check_eq("rst_m_valid", bus.m_valid, 1'b0);
    check_eq("rst_m_data", bus.m_data, 32'h0);
    check_eq("rst_m_last", bus.m_last, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_force = 1'b1;
    next_cycle();

    // Free-flowing burst: exact cycle timing
    send_cmd(8'h10, 9'd4);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        next_cycle();
        @(negedge clk);
      end
      check_eq("t1_valid", bus.m_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check_eq("t1_data", bus.m_data, 32'h110 + k - 3);
      check_eq("t1_last", bus.m_last & bus.m_valid, (k == 6));
      check_eq("t1_busy", bus.busy, (k >= 1 && k <= 6));
      check_eq("t1_done", bus.done, (k == 7));
      if (k == 1) check_eq("t1_addr", bus.mem_addr, 8'h10);
    end

    // Back-pressure until C10
    ready_force = 1'b0;
    next_cycle();
    send_cmd(8'h10, 9'd4);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        next_cycle();
        if (k == 10) ready_force = 1'b1;
        @(negedge clk);
      end
      check_eq("t2_valid", bus.m_valid, (k >= 3 && k <= 13));
      if (k >= 3 && k <= 13) check_eq("t2_data", bus.m_data, (k < 10) ? 32'h110 : 32'h110 + k - 10);
      check_eq("t2_last", bus.m_last & bus.m_valid, (k == 13));
      check_eq("t2_done", bus.done, (k == 14));
      check_eq("t2_busy", bus.busy, (k >= 1 && k <= 13));
      if (k == 9) check_eq("t2_addr_held", bus.mem_addr, 8'h14);
    end

    // Address wrap
    next_cycle();
    lc = last_cnt;
    send_cmd(8'hFE, 9'd4);
    wait_done(50, "t3_done");
    check_eq("t3_drained", exp_q.size(), 0);
    check_eq("t3_last_once", last_cnt - lc, 1);

    // Empty burst
    next_cycle();
    send_cmd(8'h33, 9'd0);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        next_cycle();
        @(negedge clk);
      end
      check_eq("t4_valid", bus.m_valid, 1'b0);
      check_eq("t4_busy", bus.busy, 1'b0);
      check_eq("t4_done", bus.done, (k == 1));
      check_eq("t4_cmd_ready", bus.cmd_ready, 1'b1);
    end

    // Random back-pressure, long burst then random short bursts
    rand_mode = 1'b1;
    next_cycle();
    lc = last_cnt;
    send_cmd(8'h00, 9'd256);
    wait_done(3000, "t5_done");
    check_eq("t5_drained", exp_q.size(), 0);
    check_eq("t5_last_once", last_cnt - lc, 1);
    for (int r = 0; r < 6; r++) begin
      logic [WL_ADDR-1:0] b;
      logic [WL_ADDR:0]   l;
      b = WL_ADDR'($urandom_range(0, 255));
      l = (WL_ADDR + 1)'($urandom_range(1, 24));
      lc = last_cnt;
      next_cycle();
      send_cmd(b, l);
      wait_done(500, "t5r_done");
      check_eq("t5r_drained", exp_q.size(), 0);
      check_eq("t5r_last_once", last_cnt - lc, 1);
    end
    check_eq("extra_words", extra_words, 0);

    // Reset in C5 of a len=8 burst
    rand_mode = 1'b0;
    ready_force = 1'b0;
    next_cycle();
    dc = done_cnt;
    send_cmd(8'h40, 9'd8);
    repeat (5) next_cycle();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t6_cmd_ready", bus.cmd_ready, 1'b1);
    check_eq("t6_mem_addr", bus.mem_addr, 8'h00);
    check_eq("t6_m_valid", bus.m_valid, 1'b0);
    check_eq("t6_m_data", bus.m_data, 32'h0);
    check_eq("t6_m_last", bus.m_last, 1'b0);
    check_eq("t6_busy", bus.busy, 1'b0);
    check_eq("t6_done", bus.done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("t6_no_done", done_cnt - dc, 0);
    ready_force = 1'b1;
    lc = last_cnt;
    next_cycle();
    send_cmd(8'h20, 9'd2);
    wait_done(50, "t6_done_after");
    check_eq("t6_drained", exp_q.size(), 0);
    check_eq("t6_last_once", last_cnt - lc, 1);
    repeat (5) next_cycle();
    @(negedge clk);
    check_eq("t6_extra_words", extra_words, 0);

    check_eq("mem_ena_zero", ena_bad, 0);
    check_eq("fifo_bound", ovf_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
